vending_machine: RTL and testbench
==================================

# vending_machine

Price-table and change-calculation core of the vending-machine datapath. Holds eight 8-bit product prices in clocked registers and selects one with a 3-bit product ID, which is also decoded to one-hot. It computes change from the amount paid and runs a 4-state purchase FSM. It sits between the keypad/coin front end and the dispense/change-return actuators.

## Interface
Parameters: none (widths fixed: 3-bit ID, 8 products, 8-bit money).

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- product_id  in  3  selected product, 0..7
- price0..price7  in  8 each  price inputs, loaded every cycle
- amount_paid  in  8  credit inserted; 0 means no payment
- decoder_out  out  8  one-hot decode of product_id, combinational
- state  out  2  FSM state register
- price  out  8  registered price of the selected product
- change  out  8  change due, combinational

## Operation
- Decoder: `decoder_out = 1 << product_id`. It is purely combinational and is not affected by reset.
- Price registers: eight 8-bit registers.
  - Each register loads its priceN input on every rising edge while reset=1.
  - Each register clears to 0 on an edge where reset=0.
- `price`: combinational 8:1 mux of the price registers, indexed by product_id.
- `change`: combinational, computed from `price` and `amount_paid`.
  - If `amount_paid >= price`: `change = amount_paid - price`.
  - Underpay: behaviour set by the macro in Configuration.
- FSM states (encoding on `state`):
  - IDLE = 00
  - CHECK = 01
  - DISPENSE = 10
  - SHORT = 11
- FSM transitions (evaluated at each rising edge with reset=1; compares use the current `price`):
  - IDLE: `amount_paid == 0` → stay IDLE; otherwise → CHECK.
  - CHECK: `amount_paid >= price` → DISPENSE; otherwise → SHORT.
  - DISPENSE: → IDLE unconditionally; held exactly one cycle.
  - SHORT: `amount_paid == 0` → IDLE; else `amount_paid >= price` → DISPENSE; otherwise stay SHORT.
- A product_id change mid-purchase takes effect immediately; the next compare uses the newly selected price.

## Timing
- Reset values:
  - state = 00.
  - All price registers = 0, so price = 0.
  - change = amount_paid; with price 0, underpay is impossible.
  - decoder_out follows product_id.
- Reset has priority over all loads and transitions. Asserting reset in any state gives IDLE on the next edge.
- Price latency: a priceN change appears on `price` one edge later, provided product_id selects N.
- After reset deasserts, the first edge loads prices. `price` is valid from that edge onward.
- product_id to `price`, `decoder_out` and `change`: combinational, zero cycles.
- A purchase takes a minimum of 3 edges: IDLE → CHECK → DISPENSE → IDLE.
- Wrap-around: no accumulation is performed. Subtraction is a single 8-bit operation, with no carry out.
- Boundary: `amount_paid == price` counts as sufficient. change = 0 and the FSM goes to DISPENSE.

## Configuration
- `VM_CHANGE_SAT_EN` defined: on underpay (`amount_paid < price`), change = 0.
- `VM_CHANGE_SAT_EN` undefined: change = `(amount_paid - price) mod 256`, a raw 8-bit wrap.
- The FSM behaviour is identical either way. SHORT is always entered on underpay.

## Test plan
- Reset:
  - Stimulus: drive reset=0 for one edge with prices 10..80 applied.
  - Required: state=00; price=0 for every product_id; product_id=5 gives decoder_out=00100000; amount_paid=25 gives change=25.
- Price load and change:
  - Stimulus: release reset, apply one edge with price0..7=10,20,…,80, then product_id=1, amount_paid=25.
  - Required: price=20, change=5, decoder_out=00000010.
- Product sweep:
  - Stimulus: product_id 2..7 with amount_paid = price+5 (35,45,…,85), one ID per cycle.
  - Required: price = 30..80, change=5 on every ID.
  - Required: decoder_out one-hot each cycle, e.g. ID 7 gives 10000000.
- Purchase FSM:
  - Stimulus: amount_paid=0 for several edges, then amount_paid=25 with product_id=1.
  - Required: state stays 00 while amount_paid=0, then follows 01, 10, 00 on successive edges.
- Underpay:
  - Stimulus: product_id=7, amount_paid=50.
  - Required: change=0 with the macro, 226 without it; state goes 00→01→11 and holds 11.
  - Stimulus: then amount_paid=85.
  - Required: next edge state=10 and change=5; following edge state=00.
- Reset mid-operation:
  - Stimulus: from SHORT, drive reset=0 for one edge.
  - Required: state=00 and price=0. After release, the first edge reloads prices and state stays 00 if amount_paid=0.

Source files
------------

// File: rtl/vending_machine_if.sv
// vending_machine_if
//   Groups the price-table / purchase datapath signals of vending_machine.
//   Signals:
//     product_id   [2:0]  selected product, 0..7
//     price0..7    [7:0]  price inputs, loaded every cycle out of reset
//     amount_paid  [7:0]  credit inserted, 0 means no payment
//     decoder_out  [7:0]  one-hot decode of product_id
//     state        [1:0]  purchase FSM state
//     price        [7:0]  registered price of the selected product
//     change       [7:0]  change due
//   Modports:
//     master : keypad/coin front end side (drives selection, prices, credit)
//     slave  : vending_machine side
interface vending_machine_if;
    logic [2:0] product_id;
    logic [7:0] price0;
    logic [7:0] price1;
    logic [7:0] price2;
    logic [7:0] price3;
    logic [7:0] price4;
    logic [7:0] price5;
    logic [7:0] price6;
    logic [7:0] price7;
    logic [7:0] amount_paid;
    logic [7:0] decoder_out;
    logic [1:0] state;
    logic [7:0] price;
    logic [7:0] change;

    modport master (
        output product_id, price0, price1, price2, price3,
               price4, price5, price6, price7, amount_paid,
        input  decoder_out, state, price, change
    );

    modport slave (
        input  product_id, price0, price1, price2, price3,
               price4, price5, price6, price7, amount_paid,
        output decoder_out, state, price, change
    );
endinterface

// File: rtl/vending_machine.sv
// vending_machine
//   Price-table and change-calculation core. Holds eight 8-bit product
//   prices in registers, selects one by product_id, decodes product_id to
//   one-hot, computes change and runs a 4-state purchase FSM.
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     reset  : synchronous, active-low reset
//     vm     : vending_machine_if.slave (selection, prices, credit in;
//              decoder_out, state, price, change out)
//   Configuration:
//     VM_CHANGE_SAT_EN : when defined, change saturates to 0 on underpay;
//                        otherwise change is the raw 8-bit wrapped difference.
module vending_machine (
    input  logic              clk,
    input  logic              reset,
    vending_machine_if.slave  vm
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CHECK    = 2'b01,
        DISPENSE = 2'b10,
        SHORT    = 2'b11
    } state_e;

    logic [7:0] price_q [8];
    state_e     state_q;
    state_e     state_d;
    logic [7:0] price_sel;
    logic [7:0] diff;
    logic       paid_enough;

    // Price table: reload every cycle while out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                price_q[i] <= '0;
            end
        end else begin
            price_q[0] <= vm.price0;
            price_q[1] <= vm.price1;
            price_q[2] <= vm.price2;
            price_q[3] <= vm.price3;
            price_q[4] <= vm.price4;
            price_q[5] <= vm.price5;
            price_q[6] <= vm.price6;
            price_q[7] <= vm.price7;
        end
    end

    assign price_sel   = price_q[vm.product_id];
    assign paid_enough = (vm.amount_paid >= price_sel);
    assign diff        = vm.amount_paid - price_sel;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Compares use the price currently selected, so a product_id change
    // mid-purchase is honoured on the very next compare.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = (vm.amount_paid == '0) ? IDLE : CHECK;
            CHECK:    state_d = paid_enough ? DISPENSE : SHORT;
            DISPENSE: state_d = IDLE;
            SHORT: begin
                if (vm.amount_paid == '0) begin
                    state_d = IDLE;
                end else if (paid_enough) begin
                    state_d = DISPENSE;
                end else begin
                    state_d = SHORT;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    assign vm.decoder_out = 8'b0000_0001 << vm.product_id;
    assign vm.state       = state_q;
    assign vm.price       = price_sel;

`ifdef VM_CHANGE_SAT_EN
    assign vm.change = paid_enough ? diff : '0;
`else
    assign vm.change = diff;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine
//   Self-checking bench for vending_machine. A behavioural model (price
//   array, purchase phase, integer change arithmetic) predicts every output;
//   directed scenarios follow the intended usage, then a randomized run.
module tb_vending_machine;

    localparam int PH_IDLE     = 0;
    localparam int PH_CHECK    = 1;
    localparam int PH_DISPENSE = 2;
    localparam int PH_SHORT    = 3;

    logic       clk;
    logic       reset;
    logic [7:0] pin [8];

    vending_machine_if vm_bus ();

    assign vm_bus.price0 = pin[0];
    assign vm_bus.price1 = pin[1];
    assign vm_bus.price2 = pin[2];
    assign vm_bus.price3 = pin[3];
    assign vm_bus.price4 = pin[4];
    assign vm_bus.price5 = pin[5];
    assign vm_bus.price6 = pin[6];
    assign vm_bus.price7 = pin[7];

    vending_machine dut (
        .clk   (clk),
        .reset (reset),
        .vm    (vm_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_price [8];
    int m_phase;

    function automatic int exp_change(input int paid, input int pr);
        if (paid >= pr) return paid - pr;
`ifdef VM_CHANGE_SAT_EN
        return 0;
`else
        return (paid - pr + 256) % 256;
`endif
    endfunction

    // Advance the model by one edge using the inputs as they stand, then
    // clock the DUT and settle.
    task automatic tick();
        int cur;
        int paid;
        cur  = m_price[vm_bus.product_id];
        paid = int'(vm_bus.amount_paid);
        if (!reset) begin
            foreach (m_price[i]) m_price[i] = 0;
            m_phase = PH_IDLE;
        end else begin
            if (m_phase == PH_IDLE)
                m_phase = (paid == 0) ? PH_IDLE : PH_CHECK;
            else if (m_phase == PH_CHECK)
                m_phase = (paid >= cur) ? PH_DISPENSE : PH_SHORT;
            else if (m_phase == PH_DISPENSE)
                m_phase = PH_IDLE;
            else if (paid == 0)
                m_phase = PH_IDLE;
            else if (paid >= cur)
                m_phase = PH_DISPENSE;
            foreach (m_price[i]) m_price[i] = int'(pin[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_prices_tens();
        for (int i = 0; i < 8; i++) pin[i] = 8'((i + 1) * 10);
    endtask

    task automatic test_reset();
        set_prices_tens();
        vm_bus.product_id  = 3'd0;
        vm_bus.amount_paid = 8'd0;
        reset = 1'b0;
        tick();
        n_checks++;
        if (vm_bus.state !== 2'b00)
            $display("FAIL reset_state: got %b expected 00", vm_bus.state);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            vm_bus.product_id = 3'(i);
            #1;
            n_checks++;
            if (vm_bus.price !== 8'd0)
                $display("FAIL reset_price[%0d]: got %0d expected 0", i, vm_bus.price);
            else n_pass++;
        end
        vm_bus.product_id = 3'd5;
        #1;
        n_checks++;
        if (vm_bus.decoder_out !== 8'b0010_0000)
            $display("FAIL reset_decoder: got %b expected 00100000", vm_bus.decoder_out);
        else n_pass++;
        vm_bus.amount_paid = 8'd25;
        #1;
        n_checks++;
        if (vm_bus.change !== 8'd25)
            $display("FAIL reset_change: got %0d expected 25", vm_bus.change);
        else n_pass++;
        vm_bus.amount_paid = 8'd0;
    endtask

    task automatic test_load_change();
        reset = 1'b1;
        set_prices_tens();
        vm_bus.amount_paid = 8'd0;
        tick();
        vm_bus.product_id  = 3'd1;
        vm_bus.amount_paid = 8'd25;
        #1;
        n_checks++;
        if (vm_bus.price !== 8'd20)
            $display("FAIL load_price: got %0d expected 20", vm_bus.price);
        else n_pass++;
        n_checks++;
        if (vm_bus.change !== 8'd5)
            $display("FAIL load_change: got %0d expected 5", vm_bus.change);
        else n_pass++;
        n_checks++;
        if (vm_bus.decoder_out !== 8'b0000_0010)
            $display("FAIL load_decoder: got %b expected 00000010", vm_bus.decoder_out);
        else n_pass++;
    endtask

    task automatic test_sweep();
        for (int id = 2; id < 8; id++) begin
            vm_bus.product_id  = 3'(id);
            vm_bus.amount_paid = 8'((id + 1) * 10 + 5);
            #1;
            n_checks++;
            if (vm_bus.price !== 8'((id + 1) * 10))
                $display("FAIL sweep_price[%0d]: got %0d expected %0d", id, vm_bus.price, (id + 1) * 10);
            else n_pass++;
            n_checks++;
            if (vm_bus.change !== 8'd5)
                $display("FAIL sweep_change[%0d]: got %0d expected 5", id, vm_bus.change);
            else n_pass++;
            n_checks++;
            if (vm_bus.decoder_out !== 8'(1 << id))
                $display("FAIL sweep_decoder[%0d]: got %b expected %b", id, vm_bus.decoder_out, 8'(1 << id));
            else n_pass++;
            tick();
            n_checks++;
            if (vm_bus.state !== 2'(m_phase))
                $display("FAIL sweep_state[%0d]: got %0d expected %0d", id, vm_bus.state, m_phase);
            else n_pass++;
        end
    endtask

    task automatic test_purchase();
        logic [1:0] seq [3];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b00;
        vm_bus.amount_paid = 8'd0;
        // Drain whatever purchase the sweep left in flight.
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (vm_bus.state !== 2'b00)
                $display("FAIL purchase_idle[%0d]: got %b expected 00", i, vm_bus.state);
            else n_pass++;
        end
        vm_bus.product_id  = 3'd1;
        vm_bus.amount_paid = 8'd25;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (vm_bus.state !== seq[i] || int'(vm_bus.state) != m_phase)
                $display("FAIL purchase_seq[%0d]: got %b expected %b", i, vm_bus.state, seq[i]);
            else n_pass++;
        end
        vm_bus.amount_paid = 8'd0;
        tick();
    endtask

    task automatic test_underpay();
        logic [1:0] seq [3];
        int exp;
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b11;
`ifdef VM_CHANGE_SAT_EN
        exp = 0;
`else
        exp = 226;
`endif
        vm_bus.product_id  = 3'd7;
        vm_bus.amount_paid = 8'd50;
        #1;
        n_checks++;
        if (vm_bus.change !== 8'(exp))
            $display("FAIL underpay_change: got %0d expected %0d", vm_bus.change, exp);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (vm_bus.state !== seq[i])
                $display("FAIL underpay_seq[%0d]: got %b expected %b", i, vm_bus.state, seq[i]);
            else n_pass++;
        end
        vm_bus.amount_paid = 8'd85;
        tick();
        n_checks++;
        if (vm_bus.state !== 2'b10)
            $display("FAIL topup_state: got %b expected 10", vm_bus.state);
        else n_pass++;
        n_checks++;
        if (vm_bus.change !== 8'd5)
            $display("FAIL topup_change: got %0d expected 5", vm_bus.change);
        else n_pass++;
        tick();
        n_checks++;
        if (vm_bus.state !== 2'b00)
            $display("FAIL topup_return: got %b expected 00", vm_bus.state);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        vm_bus.product_id  = 3'd7;
        vm_bus.amount_paid = 8'd50;
        tick();
        tick();
        n_checks++;
        if (vm_bus.state !== 2'b11)
            $display("FAIL mid_short: got %b expected 11", vm_bus.state);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (vm_bus.state !== 2'b00)
            $display("FAIL mid_reset_state: got %b expected 00", vm_bus.state);
        else n_pass++;
        n_checks++;
        if (vm_bus.price !== 8'd0)
            $display("FAIL mid_reset_price: got %0d expected 0", vm_bus.price);
        else n_pass++;
        reset = 1'b1;
        vm_bus.amount_paid = 8'd0;
        tick();
        n_checks++;
        if (vm_bus.state !== 2'b00)
            $display("FAIL mid_release_state: got %b expected 00", vm_bus.state);
        else n_pass++;
        n_checks++;
        if (vm_bus.price !== 8'd80)
            $display("FAIL mid_release_price: got %0d expected 80", vm_bus.price);
        else n_pass++;
    endtask

    task automatic test_random();
        int pid;
        int paid;
        for (int cyc = 0; cyc < 300; cyc++) begin
            reset = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 8; i++) pin[i] = 8'($urandom_range(0, 255));
            pid  = int'($urandom_range(0, 7));
            paid = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            vm_bus.product_id  = 3'(pid);
            vm_bus.amount_paid = 8'(paid);
            #1;
            n_checks++;
            if (vm_bus.decoder_out !== 8'(1 << pid))
                $display("FAIL rand_decoder@%0d: got %b expected %b", cyc, vm_bus.decoder_out, 8'(1 << pid));
            else n_pass++;
            n_checks++;
            if (vm_bus.price !== 8'(m_price[pid]))
                $display("FAIL rand_price@%0d: got %0d expected %0d", cyc, vm_bus.price, m_price[pid]);
            else n_pass++;
            n_checks++;
            if (vm_bus.change !== 8'(exp_change(paid, m_price[pid])))
                $display("FAIL rand_change@%0d: got %0d expected %0d", cyc, vm_bus.change, exp_change(paid, m_price[pid]));
            else n_pass++;
            tick();
            n_checks++;
            if (vm_bus.state !== 2'(m_phase))
                $display("FAIL rand_state@%0d: got %0d expected %0d", cyc, vm_bus.state, m_phase);
            else n_pass++;
        end
    endtask

    initial begin
        foreach (m_price[i]) m_price[i] = 0;
        m_phase = PH_IDLE;
        reset = 1'b0;
        vm_bus.product_id  = 3'd0;
        vm_bus.amount_paid = 8'd0;
        for (int i = 0; i < 8; i++) pin[i] = 8'd0;

        test_reset();
        test_load_change();
        test_sweep();
        test_purchase();
        test_underpay();
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
